// File: rtl/ramtdp.sv
// ramtdp: true dual-port synchronous RAM with per-byte write enables,
// selectable same-port read-during-write behaviour and a 1- or 2-cycle
// registered read path with valid flags. Port A wins byte lanes that both
// ports write in the same cycle; a port reading while the other writes the
// same word sees the old word.
module ramtdp #(
  parameter int    DATA_ = 32,
  parameter int    ADDR_ = 8,
  parameter int    LAT   = 1,
  parameter string MODE  = "read_first",
  parameter string RAMT  = "block"
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena_a,
  input  logic [DATA_/8-1:0] we_a,
  input  logic [ADDR_-1:0]   addr_a,
  input  logic [DATA_-1:0]   din_a,
  output logic [DATA_-1:0]   dout_a,
  output logic               vld_a,
  input  logic               ena_b,
  input  logic [DATA_/8-1:0] we_b,
  input  logic [ADDR_-1:0]   addr_b,
  input  logic [DATA_-1:0]   din_b,
  output logic [DATA_-1:0]   dout_b,
  output logic               vld_b
);

  localparam int NB    = DATA_ / 8;
  localparam int DEPTH = 2 ** ADDR_;

  localparam int MODE_RF = 0;
  localparam int MODE_WF = 1;
  localparam int MODE_NC = 2;
  localparam int MODE_I  = (MODE == "write_first") ? MODE_WF :
                           (MODE == "no_change")   ? MODE_NC : MODE_RF;

  localparam bit MODE_OK = (MODE == "read_first") || (MODE == "write_first") ||
                           (MODE == "no_change");
  localparam bit RAMT_OK = (RAMT == "auto") || (RAMT == "logic") ||
                           (RAMT == "block") || (RAMT == "ultra");

  if (DATA_ % 8 != 0) begin : g_err_data
    $error("ramtdp: DATA_ must be a multiple of 8");
  end
  if (LAT != 1 && LAT != 2) begin : g_err_lat
    $error("ramtdp: LAT must be 1 or 2");
  end
  if (!MODE_OK) begin : g_err_mode
    $error("ramtdp: unknown MODE");
  end
  if (!RAMT_OK) begin : g_err_ramt
    $error("ramtdp: unknown RAMT");
  end

  // Word with the enabled byte lanes replaced by the new data.
  function automatic logic [DATA_-1:0] merge_bytes(input logic [DATA_-1:0] old_w,
                                                   input logic [DATA_-1:0] new_w,
                                                   input logic [NB-1:0]    be);
    merge_bytes = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) merge_bytes[i*8 +: 8] = new_w[i*8 +: 8];
    end
  endfunction

  logic [DATA_-1:0] mem [DEPTH];

  // Port 0 is A, port 1 is B; both ports share one description.
  logic             ena_v  [2];
  logic [NB-1:0]    we_v   [2];
  logic [ADDR_-1:0] addr_v [2];
  logic [DATA_-1:0] din_v  [2];
  logic [DATA_-1:0] dout_v [2];
  logic             vld_v  [2];

  assign ena_v[0]  = ena_a;
  assign we_v[0]   = we_a;
  assign addr_v[0] = addr_a;
  assign din_v[0]  = din_a;
  assign ena_v[1]  = ena_b;
  assign we_v[1]   = we_b;
  assign addr_v[1] = addr_b;
  assign din_v[1]  = din_b;

  assign dout_a = dout_v[0];
  assign vld_a  = vld_v[0];
  assign dout_b = dout_v[1];
  assign vld_b  = vld_v[1];

  // Byte-lane writes; A is applied last so it owns lanes both ports enable.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (ena_v[1] && we_v[1][i]) mem[addr_v[1]][i*8 +: 8] <= din_v[1][i*8 +: 8];
      if (ena_v[0] && we_v[0][i]) mem[addr_v[0]][i*8 +: 8] <= din_v[0][i*8 +: 8];
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [DATA_-1:0] rd_word;
    logic [DATA_-1:0] dat_p1_d;
    logic [DATA_-1:0] dat_p1_q;
    logic             vld_p1_q;

    assign rd_word = mem[addr_v[p]];

    // Stage-1 data select: plain read, or the read-during-write flavour.
    always_comb begin
      dat_p1_d = dat_p1_q;
      if (ena_v[p]) begin
        if (we_v[p] == '0) begin
          dat_p1_d = rd_word;
        end else begin
          case (MODE_I)
            MODE_WF: dat_p1_d = merge_bytes(rd_word, din_v[p], we_v[p]);
            MODE_NC: dat_p1_d = dat_p1_q;
            default: dat_p1_d = rd_word;
          endcase
        end
      end
    end

    // ---- stage 1: registered read word and valid ----
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dat_p1_q <= '0;
        vld_p1_q <= 1'b0;
      end else begin
        dat_p1_q <= dat_p1_d;
        vld_p1_q <= ena_v[p];
      end
    end

    if (LAT == 2) begin : g_lat2
      logic [DATA_-1:0] dat_p2_q;
      logic             vld_p2_q;

      // ---- stage 2: extra output register, loaded only by valid data ----
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dat_p2_q <= '0;
          vld_p2_q <= 1'b0;
        end else begin
          vld_p2_q <= vld_p1_q;
          if (vld_p1_q) dat_p2_q <= dat_p1_q;
        end
      end

      assign dout_v[p] = dat_p2_q;
      assign vld_v[p]  = vld_p2_q;
    end else begin : g_lat1
      assign dout_v[p] = dat_p1_q;
      assign vld_v[p]  = vld_p1_q;
    end
  end

endmodule

// File: tb/tb_ramtdp.sv
// tb_ramtdp: four ramtdp instances (LAT/MODE combinations) share one
// stimulus stream; a word-level memory model with per-byte known masks
// predicts every port's dout/vld each cycle.
module tb_ramtdp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena_a, ena_b;
  logic [3:0]  we_a, we_b;
  logic [7:0]  addr_a, addr_b;
  logic [31:0] din_a, din_b;

  // lane = instance*2 + port (port 0 = A, 1 = B)
  logic [31:0] dout_w [8];
  logic        vld_w  [8];

  localparam int LATS  [4] = '{1, 2, 1, 2};
  localparam int MODES [4] = '{0, 1, 2, 0};  // 0 read_first, 1 write_first, 2 no_change

  always #5 clk = ~clk;

  ramtdp #(.DATA_(32), .ADDR_(8), .LAT(1), .MODE("read_first"), .RAMT("block")) u0 (
    .clk(clk), .rst_n(rst_n),
    .ena_a(ena_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_w[0]), .vld_a(vld_w[0]),
    .ena_b(ena_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_w[1]), .vld_b(vld_w[1]));
  ramtdp #(.DATA_(32), .ADDR_(8), .LAT(2), .MODE("write_first"), .RAMT("auto")) u1 (
    .clk(clk), .rst_n(rst_n),
    .ena_a(ena_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_w[2]), .vld_a(vld_w[2]),
    .ena_b(ena_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_w[3]), .vld_b(vld_w[3]));
  ramtdp #(.DATA_(32), .ADDR_(8), .LAT(1), .MODE("no_change"), .RAMT("logic")) u2 (
    .clk(clk), .rst_n(rst_n),
    .ena_a(ena_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_w[4]), .vld_a(vld_w[4]),
    .ena_b(ena_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_w[5]), .vld_b(vld_w[5]));
  ramtdp #(.DATA_(32), .ADDR_(8), .LAT(2), .MODE("read_first"), .RAMT("ultra")) u3 (
    .clk(clk), .rst_n(rst_n),
    .ena_a(ena_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_w[6]), .vld_a(vld_w[6]),
    .ena_b(ena_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_w[7]), .vld_b(vld_w[7]));

  int tests = 0;
  int fails = 0;

  // Reference model: memory words plus a mask of bytes that have been written.
  logic [31:0] mem_m [256];
  logic [31:0] kn_m  [256];
  int          rdy_q [8][$];
  logic [31:0] dat_q [8][$];
  logic [31:0] msk_q [8][$];
  logic [31:0] cur   [8];
  logic [31:0] curm  [8];
  logic [31:0] lastw [8];
  logic [31:0] lastm [8];
  int          t = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = be[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < 8; l++) begin
      rdy_q[l].delete();
      dat_q[l].delete();
      msk_q[l].delete();
      cur[l]   = '0;
      curm[l]  = '1;
      lastw[l] = '0;
      lastm[l] = '1;
    end
  endtask

  // One issued access on a lane: decide the word it returns and when.
  task automatic issue(input int lane, input int k, input logic [31:0] old_w,
                       input logic [31:0] old_m, input logic [31:0] din, input logic [3:0] we);
    logic [31:0] w, m, bm;
    bm = bmask(we);
    w = old_w;
    m = old_m;
    if (we != 4'b0) begin
      if (MODES[k] == 1) begin
        w = (old_w & ~bm) | (din & bm);
        m = old_m | bm;
      end else if (MODES[k] == 2) begin
        w = lastw[lane];
        m = lastm[lane];
      end
    end
    lastw[lane] = w;
    lastm[lane] = m;
    rdy_q[lane].push_back(t + LATS[k] - 1);
    dat_q[lane].push_back(w);
    msk_q[lane].push_back(m);
  endtask

  task automatic model_edge();
    logic [31:0] oa, ma, ob, mb, bm;
    t++;
    oa = mem_m[addr_a]; ma = kn_m[addr_a];
    ob = mem_m[addr_b]; mb = kn_m[addr_b];
    for (int k = 0; k < 4; k++) begin
      if (ena_a) issue(k*2,     k, oa, ma, din_a, we_a);
      if (ena_b) issue(k*2 + 1, k, ob, mb, din_b, we_b);
    end
    if (ena_b) begin
      bm = bmask(we_b);
      mem_m[addr_b] = (mem_m[addr_b] & ~bm) | (din_b & bm);
      kn_m[addr_b]  = kn_m[addr_b] | bm;
    end
    if (ena_a) begin
      bm = bmask(we_a);
      mem_m[addr_a] = (mem_m[addr_a] & ~bm) | (din_a & bm);
      kn_m[addr_a]  = kn_m[addr_a] | bm;
    end
  endtask

  task automatic check_all();
    logic expv;
    for (int l = 0; l < 8; l++) begin
      expv = 1'b0;
      if (rdy_q[l].size() > 0 && rdy_q[l][0] == t) begin
        cur[l]  = dat_q[l].pop_front();
        curm[l] = msk_q[l].pop_front();
        void'(rdy_q[l].pop_front());
        expv = 1'b1;
      end
      chk($sformatf("vld lane%0d t%0d", l, t), {31'b0, vld_w[l]}, {31'b0, expv});
      chk($sformatf("dout lane%0d t%0d", l, t), dout_w[l] & curm[l], cur[l] & curm[l]);
    end
  endtask

  task automatic step(input logic ea, input logic [3:0] wa, input logic [7:0] aa, input logic [31:0] da,
                      input logic eb, input logic [3:0] wb, input logic [7:0] ab, input logic [31:0] db);
    @(negedge clk);
    ena_a = ea; we_a = wa; addr_a = aa; din_a = da;
    ena_b = eb; we_b = wb; addr_b = ab; din_b = db;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 8'h0, 32'h0, 1'b0, 4'h0, 8'h0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_m[i] = '0;
      kn_m[i]  = '0;
    end
    model_reset();
    rst_n = 1'b0;
    ena_a = 1'b0; we_a = '0; addr_a = '0; din_a = '0;
    ena_b = 1'b0; we_b = '0; addr_b = '0; din_b = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int l = 0; l < 8; l++) begin
      chk($sformatf("reset dout lane%0d", l), dout_w[l], 32'h0);
      chk($sformatf("reset vld lane%0d", l), {31'b0, vld_w[l]}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Streaming: fill every word from A, then read them all back on B.
    for (int i = 0; i < 256; i++) step(1'b1, 4'hF, 8'(i), 32'(i * 3), 1'b0, 4'h0, 8'h0, 32'h0);
    for (int i = 0; i < 256; i++) step(1'b0, 4'h0, 8'h0, 32'h0, 1'b1, 4'h0, 8'(i), 32'h0);
    chk("stream last B lat1", dout_w[1], 32'd765);
    repeat (3) idle();
    chk("stream hold B lat1", dout_w[1], 32'd765);
    chk("stream hold B lat2", dout_w[7], 32'd765);

    // Byte-enable merge.
    step(1'b1, 4'hF, 8'd5, 32'hDEADBEEF, 1'b0, 4'h0, 8'h0, 32'h0);
    step(1'b1, 4'b0010, 8'd5, 32'h0000AA00, 1'b0, 4'h0, 8'h0, 32'h0);
    step(1'b0, 4'h0, 8'h0, 32'h0, 1'b1, 4'h0, 8'd5, 32'h0);
    chk("be lat1 data", dout_w[1], 32'hDEADAAEF);
    chk("be lat1 vld", {31'b0, vld_w[1]}, 32'h1);
    chk("be lat2 vld early", {31'b0, vld_w[3]}, 32'h0);
    idle();
    chk("be lat2 data", dout_w[3], 32'hDEADAAEF);
    chk("be lat2 vld", {31'b0, vld_w[3]}, 32'h1);
    chk("be lat1 vld drop", {31'b0, vld_w[1]}, 32'h0);

    // Same-port read-during-write.
    step(1'b1, 4'hF, 8'd3, 32'h11111111, 1'b0, 4'h0, 8'h0, 32'h0);
    idle();
    step(1'b1, 4'hF, 8'd3, 32'h22222222, 1'b0, 4'h0, 8'h0, 32'h0);
    chk("rdw read_first", dout_w[0], 32'h11111111);
    chk("rdw no_change vld", {31'b0, vld_w[4]}, 32'h1);
    idle();
    chk("rdw write_first lat2", dout_w[2], 32'h22222222);
    chk("rdw read_first lat2", dout_w[6], 32'h11111111);

    // Cross-port read of a word being written.
    step(1'b1, 4'hF, 8'd7, 32'h0, 1'b0, 4'h0, 8'h0, 32'h0);
    step(1'b1, 4'hF, 8'd7, 32'h12345678, 1'b1, 4'h0, 8'd7, 32'h0);
    chk("cross old word", dout_w[1], 32'h0);
    step(1'b0, 4'h0, 8'h0, 32'h0, 1'b1, 4'h0, 8'd7, 32'h0);
    chk("cross new word", dout_w[1], 32'h12345678);

    // Write collision, A owns shared lanes.
    step(1'b1, 4'b0011, 8'd9, 32'hAAAAAAAA, 1'b1, 4'b1110, 8'd9, 32'hBBBBBBBB);
    step(1'b1, 4'h0, 8'd9, 32'h0, 1'b0, 4'h0, 8'h0, 32'h0);
    chk("collision word", dout_w[0], 32'hBBBBAAAA);

    // Randomised traffic on a small address window to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
           8'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
           8'($urandom_range(0, 15)), $urandom);
    end
    repeat (2) idle();

    // Reset with a read in flight.
    step(1'b1, 4'h0, 8'd5, 32'h0, 1'b1, 4'h0, 8'd5, 32'h0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int l = 0; l < 8; l++) begin
      chk($sformatf("midreset dout lane%0d", l), dout_w[l], 32'h0);
      chk($sformatf("midreset vld lane%0d", l), {31'b0, vld_w[l]}, 32'h0);
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle();
    step(1'b0, 4'h0, 8'h0, 32'h0, 1'b1, 4'h0, 8'd200, 32'h0);
    chk("post reset read", dout_w[1], 32'd600);
    repeat (2) idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
